wb_arbiter: RTL and testbench

Write-back arbiter and register scoreboard that owns the register file's single write port (`a3`/`we3`/`wd`). It merges results from the single-cycle ALU path and the multi-cycle mul/div unit. ALU results have priority; mul/div results are buffered in a small FIFO. It also tracks destination registers of in-flight mul/div operations so that decode can stall on read-after-write hazards.

---
 rtl/riscv_structures.sv | 15 +
 rtl/wb_fifo.sv | 63 ++++++
 rtl/wb_arbiter.sv | 111 +++++++++++
 tb/tb_wb_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_structures.sv
// Shared types for the write-back path: register-file write entry and the x0 alias.
// No logic, no latency.
// No flow control of its own.
package riscv_structures;

  // Register index that is hardwired to zero; writes to it are discarded.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer holding mul/div write-back entries in arrival order.
// Latency: an entry pushed at edge N is visible at the head after that edge; no push-to-pop bypass.
// Backpressure: push is ignored when full (even if popping), pop is ignored when empty.
module wb_fifo
  import riscv_structures::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  wb_entry_t                  push_dat,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Owns the register-file write port: ALU results first, buffered mul/div results otherwise; tracks in-flight mul/div destinations.
// Latency: ALU result on rf_* one cycle after alu_valid; mul/div entry at earliest two cycles after its push.
// Backpressure: md_ready drops when the FIFO is full; ALU is always accepted and may starve the FIFO.
module wb_arbiter
  import riscv_structures::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  output logic        busy1,
  output logic        busy2,
  output logic [4:0]  rf_a3,
  output logic        rf_we3,
  output logic [31:0] rf_wd
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  wb_entry_t   md_entry;
  wb_entry_t   md_head;
  logic        md_full;
  logic        md_empty;
  logic [AW:0] md_count;
  logic        md_push;
  logic        md_pop;
  logic        alu_win;
  logic        head_writes;
  logic [31:0] pending;
  logic [31:0] pending_nxt;

  assign md_entry    = '{rd: md_rd, data: md_data};
  assign md_ready    = (md_count != CNT_FULL);
  assign md_push     = md_valid && !md_full;

  // An ALU write to x0 is dropped and leaves the port free for the FIFO.
  assign alu_win     = alu_valid && (alu_rd != REG_ZERO);
  assign md_pop      = !alu_win && !md_empty;
  assign head_writes = (md_head.rd != REG_ZERO);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_md_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (md_push),
    .push_dat (md_entry),
    .pop      (md_pop),
    .head     (md_head),
    .full     (md_full),
    .empty    (md_empty),
    .count    (md_count)
  );

  // Registered write port: ALU beats FIFO; address/data hold when nothing is selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we3 <= 1'b0;
      rf_a3  <= REG_ZERO;
      rf_wd  <= '0;
    end else if (alu_win) begin
      rf_we3 <= 1'b1;
      rf_a3  <= alu_rd;
      rf_wd  <= alu_data;
    end else if (md_pop) begin
      rf_we3 <= head_writes;
      rf_a3  <= md_head.rd;
      rf_wd  <= md_head.data;
    end else begin
      rf_we3 <= 1'b0;
    end
  end

  // Scoreboard next state: clear on a real pop, then set on issue so a same-cycle set wins.
  always_comb begin
    pending_nxt = pending;
    if (md_pop && head_writes) begin
      pending_nxt[md_head.rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != REG_ZERO)) begin
      pending_nxt[issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Hazard lookup straight from the register; a pop this cycle is not bypassed.
  assign busy1 = pending[q_rs1];
  assign busy2 = pending[q_rs2];

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic against a queue-based model.
// Latency: checks rf_* one cycle after the inputs of each step.
// Backpressure: model mirrors FIFO occupancy to predict md_ready.
module tb_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        busy1;
  logic        busy2;
  logic [4:0]  rf_a3;
  logic        rf_we3;
  logic [31:0] rf_wd;

  int passes = 0;
  int total  = 0;
  int fails  = 0;

  // Reference model: queue of {rd,data}, set of pending registers, expected port regs.
  logic [36:0] mq[$];
  bit   [31:0] m_pend;
  logic        e_we;
  logic [4:0]  e_a3;
  logic [31:0] e_wd;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .md_valid    (md_valid),
    .md_ready    (md_ready),
    .md_rd       (md_rd),
    .md_data     (md_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .q_rs1       (q_rs1),
    .q_rs2       (q_rs2),
    .busy1       (busy1),
    .busy2       (busy2),
    .rf_a3       (rf_a3),
    .rf_we3      (rf_we3),
    .rf_wd       (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = '0;
    e_we   = 1'b0;
    e_a3   = 5'd0;
    e_wd   = 32'd0;
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    alu_rd      = 5'd0;
    alu_data    = 32'd0;
    md_valid    = 1'b0;
    md_rd       = 5'd0;
    md_data     = 32'd0;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
  endtask

  // One cycle: called at a negedge with inputs already applied.
  task automatic tick();
    logic        push;
    logic        alu_win;
    logic        pop;
    logic [36:0] h;
    #1;
    chk("md_ready", {31'd0, md_ready}, {31'd0, mq.size() != DEPTH});
    chk("busy1", {31'd0, busy1}, {31'd0, m_pend[q_rs1]});
    chk("busy2", {31'd0, busy2}, {31'd0, m_pend[q_rs2]});
    push    = md_valid && (mq.size() != DEPTH);
    alu_win = alu_valid && (alu_rd != 5'd0);
    pop     = !alu_win && (mq.size() != 0);
    if (alu_win) begin
      e_we = 1'b1;
      e_a3 = alu_rd;
      e_wd = alu_data;
    end else if (pop) begin
      h    = mq.pop_front();
      e_a3 = h[36:32];
      e_wd = h[31:0];
      e_we = (h[36:32] != 5'd0);
      if (e_we) m_pend[h[36:32]] = 1'b0;
    end else begin
      e_we = 1'b0;
    end
    if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
    if (push) mq.push_back({md_rd, md_data});
    @(posedge clk);
    @(negedge clk);
    chk("rf_we3", {31'd0, rf_we3}, {31'd0, e_we});
    chk("rf_a3", {27'd0, rf_a3}, {27'd0, e_a3});
    chk("rf_wd", rf_wd, e_wd);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    q_rs1 = 5'd0;
    q_rs2 = 5'd0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset values while reset is held.
    chk("rst_we3", {31'd0, rf_we3}, 32'd0);
    chk("rst_a3", {27'd0, rf_a3}, 32'd0);
    chk("rst_wd", rf_wd, 32'd0);
    chk("rst_ready", {31'd0, md_ready}, 32'd1);
    rst_n = 1'b1;

    // Quiet period after release.
    q_rs1 = 5'd3;
    q_rs2 = 5'd9;
    repeat (5) tick();

    // ALU priority over a simultaneous mul/div push.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
    md_valid = 1'b1; md_rd = 5'd6; md_data = 32'h22;
    tick();
    chk("prio_a3_alu", {27'd0, rf_a3}, 32'd5);
    chk("prio_wd_alu", rf_wd, 32'h11);
    idle_inputs();
    tick();
    chk("prio_a3_md", {27'd0, rf_a3}, 32'd6);
    chk("prio_wd_md", rf_wd, 32'h22);

    // Fill the FIFO while the ALU holds the port, then drain in order.
    alu_valid = 1'b1; alu_rd = 5'd1;
    for (int i = 0; i < DEPTH; i++) begin
      alu_data = 32'h100 + 32'(i);
      md_valid = 1'b1; md_rd = 5'(10 + i); md_data = 32'hA0 + 32'(i);
      tick();
    end
    md_valid = 1'b0;
    tick();
    chk("full_ready", {31'd0, md_ready}, 32'd0);
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("drain_order", rf_wd, 32'hA0 + 32'(i));
    end

    // Scoreboard set, clear on pop, and set-wins on a simultaneous pop.
    q_rs1 = 5'd7;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle_inputs();
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h77;
    tick();
    chk("sb_busy_set", {31'd0, busy1}, 32'd1);
    idle_inputs();
    tick();
    tick();
    chk("sb_busy_clr", {31'd0, busy1}, 32'd0);
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h78;
    tick();
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle_inputs();
    tick();
    chk("sb_set_wins", {31'd0, busy1}, 32'd1);

    // x0 handling: ALU to x0 lets the FIFO pop; md to x0 pops without writing; issue to x0 never busy.
    md_valid = 1'b1; md_rd = 5'd12; md_data = 32'hC0DE;
    tick();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    tick();
    chk("x0_alu_pop", rf_wd, 32'hC0DE);
    idle_inputs();
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h5A5A;
    tick();
    idle_inputs();
    tick();
    chk("x0_md_we", {31'd0, rf_we3}, 32'd0);
    chk("x0_md_wd", rf_wd, 32'h5A5A);
    q_rs2 = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    idle_inputs();
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      alu_valid   = ($urandom_range(0, 2) == 0);
      alu_rd      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_data    = $urandom;
      md_valid    = ($urandom_range(0, 1) == 0);
      md_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      md_data     = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 31));
      q_rs1       = 5'($urandom_range(0, 31));
      q_rs2       = 5'($urandom_range(0, 31));
      tick();
    end
    idle_inputs();
    repeat (DEPTH + 1) tick();

    // Reset in the middle of a drain with entries queued and a register pending.
    q_rs1 = 5'd20;
    issue_valid = 1'b1; issue_rd = 5'd20;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    for (int i = 0; i < 3; i++) begin
      md_valid = 1'b1; md_rd = 5'(20 + i); md_data = 32'hB0 + 32'(i);
      tick();
      issue_valid = 1'b0;
    end
    idle_inputs();
    chk("mid_busy_before", {31'd0, busy1}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we3", {31'd0, rf_we3}, 32'd0);
    chk("mid_rst_ready", {31'd0, md_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy1}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
